// File: rtl/logic_gate_pkg.sv
// Shared types for logic_gate_pipe: gate opcodes, sweep FSM states and the
// single-bit gate evaluator applied across the operand width.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_CHECK = 2'd2
  } sweep_state_e;

  localparam int SWEEP_VECTORS = 32;

  // Per-bit evaluation keeps the function independent of WIDTH.
  function automatic logic gate_eval(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_skid.sv
// Two-entry valid/ready register slice: an output register plus one skid register,
// with in_ready taken straight from a flop so it never depends on out_ready.
module logic_gate_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_full_q, skid_full_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready_o  = ~skid_full_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

  assign in_fire  = in_valid_i & ~skid_full_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    out_d       = out_q;
    skid_d      = skid_q;
    if (out_fire) begin
      // A full skid blocks in_fire, so draining it and accepting never coincide.
      if (skid_full_q) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end else if (in_fire) begin
        out_d = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_d       = in_data_i;
        out_valid_d = 1'b1;
      end
    end else if (in_fire) begin
      skid_d      = in_data_i;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered WIDTH-bit bitwise gate unit with valid/ready handshakes and a 2-entry skid.
// Optional truth-table sweep self-test when LOGIC_GATE_PIPE_SWEEP_EN is defined.
//
//   state    | meaning
//   SW_IDLE  | normal pipeline traffic, waiting for sweep_start
//   SW_RUN   | generator issues 32 op/pattern vectors, pipeline handshakes frozen
//   SW_CHECK | final compare, sweep_done pulse, back to idle
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  input  logic             sweep_start_i,
  output logic             sweep_busy_o,
  output logic             sweep_done_o,
  output logic             sweep_fail_o
);

  logic [WIDTH-1:0] res;
  logic             skid_in_ready, skid_out_valid;
  logic             sweep_hold;

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) res[i] = gate_eval(op_e'(op_i), a_i[i], b_i[i]);
  end

  // The sweep freezes both handshakes so any held beat survives the self-test.
  assign in_ready_o  = skid_in_ready & ~sweep_hold;
  assign out_valid_o = skid_out_valid & ~sweep_hold;

  logic_gate_skid #(.WIDTH(WIDTH)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i & ~sweep_hold),
    .in_ready_o  (skid_in_ready),
    .in_data_i   (res),
    .out_valid_o (skid_out_valid),
    .out_ready_i (out_ready_i & ~sweep_hold),
    .out_data_o  (y_o)
  );

`ifdef LOGIC_GATE_PIPE_SWEEP_EN
  sweep_state_e     state_q;
  logic [4:0]       idx_q;
  logic             busy_q, done_q, fail_q;
  logic             chk_v_q, chk_exp_q;
  logic [WIDTH-1:0] chk_res_q;
  logic [WIDTH-1:0] gen_a, gen_b, gen_res;
  logic [3:0]       ref_tt;
  op_e              gen_op;

  assign gen_op = op_e'(idx_q[4:2]);
  assign gen_a  = {WIDTH{idx_q[1]}};
  assign gen_b  = {WIDTH{idx_q[0]}};

  always_comb begin
    gen_res = '0;
    for (int i = 0; i < WIDTH; i++) gen_res[i] = gate_eval(gen_op, gen_a[i], gen_b[i]);
  end

  // Reference truth tables indexed by {a,b}, deliberately not derived from gate_eval.
  always_comb begin
    case (idx_q[4:2])
      3'd0:    ref_tt = 4'b1000;
      3'd1:    ref_tt = 4'b1110;
      3'd2:    ref_tt = 4'b0110;
      3'd3:    ref_tt = 4'b0111;
      3'd4:    ref_tt = 4'b0001;
      3'd5:    ref_tt = 4'b1001;
      3'd6:    ref_tt = 4'b0011;
      default: ref_tt = 4'b1100;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SW_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      chk_v_q   <= 1'b0;
      chk_exp_q <= 1'b0;
      chk_res_q <= '0;
    end else begin
      done_q  <= 1'b0;
      chk_v_q <= 1'b0;
      if (chk_v_q && (chk_res_q != {WIDTH{chk_exp_q}})) fail_q <= 1'b1;
      case (state_q)
        SW_IDLE: begin
          if (sweep_start_i && !skid_out_valid && skid_in_ready) begin
            state_q <= SW_RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            fail_q  <= 1'b0;
          end
        end
        SW_RUN: begin
          chk_v_q   <= 1'b1;
          chk_res_q <= gen_res;
          chk_exp_q <= ref_tt[idx_q[1:0]];
          idx_q     <= idx_q + 5'd1;
          if (idx_q == 5'(SWEEP_VECTORS - 1)) begin
            state_q <= SW_CHECK;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= SW_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_hold   = busy_q;
  assign sweep_busy_o = busy_q;
  assign sweep_done_o = done_q;
  assign sweep_fail_o = fail_q;
`else
  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start_i;
  assign sweep_hold   = 1'b0;
  assign sweep_busy_o = 1'b0;
  assign sweep_done_o = 1'b0;
  assign sweep_fail_o = 1'b0;
`endif

endmodule
